// File: rtl/apb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_uart_rx : APB slave 8N1 UART receiver feeding a byte FIFO  | Rev 1.0
// ---------------------------------------------------------------------------
module apb_uart_rx #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_EXP   = 4,
  parameter int CLK_DIV    = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic                  rx_wire,
  output logic                  rx_int
);

  localparam int DEPTH = 1 << ADDR_EXP;
  localparam int CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0]     HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]     FULL_LOAD = CW'(CLK_DIV - 1);
  localparam logic [ADDR_EXP:0] DEPTH_CNT = (ADDR_EXP + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t              state;
  logic                rx_meta;
  logic                rxs;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_EXP-1:0] wr_ptr;
  logic [ADDR_EXP-1:0] rd_ptr;
  logic [ADDR_EXP:0]   count;
  logic                frame_err;
  logic                overrun;

  logic       access, rd, wr, empty, full;
  logic       stop_hit, push, pop, accept;
  logic       set_fe, clr_fe, set_ov, clr_ov;
  logic [1:0] addr;
  logic       unused_bits;

  assign addr     = S_PADDR[1:0];
  assign access   = S_PSELx & S_PENABLE;
  assign rd       = access & ~S_PWRITE;
  assign wr       = access & S_PWRITE;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign stop_hit = (state == ST_STOP) && (cnt == '0);
  assign push     = stop_hit & rxs;
  assign pop      = rd && (addr == 2'd0) && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign accept   = push && (!full || pop);
  assign set_fe   = stop_hit & ~rxs;
  assign clr_fe   = wr && (addr == 2'd2) && S_PWDATA[2];
  assign set_ov   = push && full && !pop;
  assign clr_ov   = wr && (addr == 2'd2) && S_PWDATA[3];

  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:4], S_PWDATA[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx_wire;
      rxs     <= rx_meta;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) state <= rxs ? ST_IDLE : ST_BREAK;
          else           cnt   <= cnt - 1'b1;
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (set_fe)      frame_err <= 1'b1;
      else if (clr_fe) frame_err <= 1'b0;
      if (set_ov)      overrun <= 1'b1;
      else if (clr_ov) overrun <= 1'b0;
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (rd) begin
      case (addr)
        2'd0: begin
          if (!empty) S_PRDATA[8:0] = {1'b1, mem[rd_ptr]};
        end
        2'd1: begin
          S_PRDATA[0]            = empty;
          S_PRDATA[1]            = full;
          S_PRDATA[2]            = frame_err;
          S_PRDATA[3]            = overrun;
          S_PRDATA[ADDR_EXP+8:8] = count;
        end
        default: S_PRDATA = '0;
      endcase
    end
  end

  assign S_PREADY = access;
  assign rx_int   = ~empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_uart_rx : directed + random bench with queue reference model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_uart_rx;

  localparam int DIV   = 16;
  localparam int DEPTH = 16;
  // Edge-to-push delay: 2 sync flops, 1 detect cycle, half bit, 9 full bits.
  localparam int PUSH_DLY = 3 + DIV / 2 + 9 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        rx_wire;
  logic        rx_int;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  bit         m_fe, m_ov;

  apb_uart_rx #(.BUS_WIDTH(32), .DATA_WIDTH(32), .ADDR_EXP(4), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel),
    .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx_wire), .rx_int(rx_int)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int n = q.size();
    return (32'(n) << 8) | (32'(m_ov) << 3) | (32'(m_fe) << 2) |
           (32'(n == DEPTH) << 1) | 32'(n == 0);
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ov = 1'b1;
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
    paddr = {30'd0, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    check("pready_rd", {31'd0, pready}, 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    paddr = {30'd0, a}; pwrite = 1'b1; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d, e;
    e = (q.size() > 0) ? {23'd0, 1'b1, q.pop_front()} : 32'd0;
    apb_read(2'd0, d);
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    apb_read(2'd1, d);
    check(tag, d, exp_status());
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_wire = bits[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b, b2;
    reset = 1'b1; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    pwdata = '0; rx_wire = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_rx_int", {31'd0, rx_int}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    read_status("rst_status");

    // Two back-to-back frames
    send_frame(8'h55, 1'b1); model_push(8'h55);
    send_frame(8'hA3, 1'b1); model_push(8'hA3);
    read_status("t1_status");
    check("t1_rx_int", {31'd0, rx_int}, 32'd1);
    read_data("t1_data0");
    read_data("t1_data1");
    read_data("t1_empty");
    check("t1_rx_int_low", {31'd0, rx_int}, 32'd0);
    apb_read(2'd2, d); check("rd_addr2", d, 32'd0);
    apb_read(2'd3, d); check("rd_addr3", d, 32'd0);

    // Short low glitch is a false start
    rx_wire = 1'b0; repeat (4) @(negedge clk);
    rx_wire = 1'b1; repeat (3 * DIV) @(negedge clk);
    read_status("t2_status");
    check("t2_status_const", exp_status(), 32'h001);

    // Framing error followed by a held-low line, then a good frame
    send_frame(8'h3C, 1'b0); m_fe = 1'b1;
    repeat (100) @(negedge clk);
    rx_wire = 1'b1; repeat (2 * DIV) @(negedge clk);
    send_frame(8'h7E, 1'b1); model_push(8'h7E);
    read_status("t3_status_fe");
    apb_write(2'd0, 32'hFFFF_FFFF);
    apb_write(2'd1, 32'hFFFF_FFFF);
    read_status("t3_ignored_wr");
    apb_write(2'd2, 32'h4); m_fe = 1'b0;
    read_status("t3_status_clr");
    read_data("t3_data");

    // Overflow: 17 bytes into a 16-entry FIFO
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1); model_push(8'(i));
    end
    read_status("t4_status_ovr");
    apb_write(2'd2, 32'h8); m_ov = 1'b0;
    read_status("t4_status_clr");
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("t4_data%0d", i));
    read_data("t4_empty");

    // DATA read in the push cycle with one byte queued
    b = 8'($urandom); b2 = 8'($urandom);
    send_frame(b, 1'b1); model_push(b);
    fork
      send_frame(b2, 1'b1);
      begin
        repeat (PUSH_DLY - 2) @(negedge clk);
        apb_read(2'd0, d);
      end
    join
    check("t5_pop_push", d, {23'd0, 1'b1, q.pop_front()});
    model_push(b2);
    read_status("t5_status_one");
    // Full FIFO with a pop in the push cycle: no overrun
    for (int i = 0; i < DEPTH - 1; i++) begin
      b = 8'($urandom); send_frame(b, 1'b1); model_push(b);
    end
    read_status("t5_status_full");
    b2 = 8'($urandom);
    fork
      send_frame(b2, 1'b1);
      begin
        repeat (PUSH_DLY - 2) @(negedge clk);
        apb_read(2'd0, d);
      end
    join
    check("t5_full_pop", d, {23'd0, 1'b1, q.pop_front()});
    model_push(b2);
    read_status("t5_status_noovr");
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("t5_data%0d", i));

    // Random frames with random interleaved reads
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1); model_push(b);
      if ($urandom_range(0, 1) == 1) read_data($sformatf("rnd_data%0d", i));
    end
    read_status("rnd_status");

    // Reset in the middle of a frame
    rx_wire = 1'b0; repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_wire = 1'b0; repeat (DIV) @(negedge clk);
    end
    rx_wire = 1'b1; repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rx_int", {31'd0, rx_int}, 32'd0);
    check("t6_prdata", prdata, 32'd0);
    check("t6_pready", {31'd0, pready}, 32'd0);
    q.delete(); m_fe = 1'b0; m_ov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    read_status("t6_status");
    send_frame(8'h81, 1'b1); model_push(8'h81);
    read_data("t6_data");
    read_status("t6_final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
